receivers_top_level_sim: RTL and testbench

- Top-level receiver block for three light-sensor channels. Each channel has an envelope line and a data line.
- On each data line the block decodes a biphase-mark-coded (BMC) bitstream into 17-bit words. It then serialises each word, tagged with its channel index, as a 3-byte 8N1 UART packet on tx.
- Sits between the sensor front-ends and the host serial link.

---
 rtl/receivers_top_level_sim.sv | 254 +++++++++++++++++++++++++
 tb/tb_receivers_top_level_sim.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/receivers_top_level_sim.sv
// Three-channel biphase-mark receiver: decodes 17-bit words from each light sensor
// and forwards each one as a channel-tagged 3-byte 8N1 packet on tx.
module receivers_top_level_sim #(
   parameter int CLK_HZ    = 25000000,
   parameter int BAUD_DIV  = 217,
   parameter int SHORT_MAX = 12,
   parameter int LONG_MAX  = 24,
   parameter int WORD_BITS = 17
) (
   input  logic clk_25MHz,
   input  logic reset,
   input  logic envelop_wire_0,
   input  logic envelop_wire_1,
   input  logic envelop_wire_2,
   input  logic data_wire_0,
   input  logic data_wire_1,
   input  logic data_wire_2,
   output logic tx
);
   localparam int NCH = 3;
   localparam int BCW = $clog2(WORD_BITS);
   // A non-positive BAUD_DIV falls back to 115200 baud derived from the clock.
   localparam int BAUD_EFF = (BAUD_DIV > 0) ? BAUD_DIV : CLK_HZ / 115200;

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_HALF} dec_state_e;
   typedef enum logic       {U_IDLE, U_SEND} uart_state_e;

   logic [NCH-1:0]       data_meta_q, data_meta_d, data_sync_q, data_sync_d;
   logic [NCH-1:0]       data_prev_q, data_prev_d;
   logic [NCH-1:0]       env_meta_q, env_meta_d, env_sync_q, env_sync_d;
   logic [NCH-1:0]       edge_det, is_short, tmo, word_done;

   dec_state_e           st_q     [NCH];
   dec_state_e           st_d     [NCH];
   logic [7:0]           cnt_q    [NCH];
   logic [7:0]           cnt_d    [NCH];
   logic [BCW-1:0]       bits_q   [NCH];
   logic [BCW-1:0]       bits_d   [NCH];
   logic [WORD_BITS-1:0] shreg_q  [NCH];
   logic [WORD_BITS-1:0] shreg_d  [NCH];
   logic [WORD_BITS-1:0] new_word [NCH];
   logic [WORD_BITS-1:0] pend_w_q [NCH];
   logic [WORD_BITS-1:0] pend_w_d [NCH];
   logic [NCH-1:0]       pend_v_q, pend_v_d, grant;

   uart_state_e          u_st_q, u_st_d;
   logic [15:0]          baud_q, baud_d;
   logic [3:0]           bit_q, bit_d;
   logic [1:0]           byte_q, byte_d;
   logic [9:0]           frame_q, frame_d;
   logic [15:0]          rest_q, rest_d;
   logic                 uart_free, frame_end;
   logic [1:0]           sel_ch;
   logic [WORD_BITS-1:0] sel_w;

   always_comb begin
      data_meta_d = {data_wire_2, data_wire_1, data_wire_0};
      data_sync_d = data_meta_q;
      data_prev_d = data_sync_q;
      env_meta_d  = {envelop_wire_2, envelop_wire_1, envelop_wire_0};
      env_sync_d  = env_meta_q;
   end

   assign edge_det = data_sync_q ^ data_prev_q;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         is_short[i] = cnt_q[i] < 8'(SHORT_MAX);
         tmo[i]      = cnt_q[i] > 8'(LONG_MAX);
      end
   end

   // cnt holds the cycles since the previous edge, so on an edge it equals the interval.
   always_comb begin
      logic do_shift;
      logic bit_val;
      for (int i = 0; i < NCH; i++) begin
         st_d[i]      = st_q[i];
         bits_d[i]    = bits_q[i];
         shreg_d[i]   = shreg_q[i];
         cnt_d[i]     = edge_det[i] ? 8'd1 :
                        ((cnt_q[i] == 8'hFF) ? cnt_q[i] : cnt_q[i] + 8'd1);
         word_done[i] = 1'b0;
         do_shift     = 1'b0;
         bit_val      = 1'b0;
         if (env_sync_q[i]) begin
            st_d[i] = ST_IDLE;
         end else begin
            case (st_q[i])
               ST_IDLE: begin
                  if (edge_det[i]) begin
                     st_d[i]    = ST_SYNC;
                     bits_d[i]  = '0;
                     shreg_d[i] = '0;
                  end
               end
               ST_SYNC, ST_HALF: begin
                  if (edge_det[i] && tmo[i]) begin
                     st_d[i]    = ST_SYNC;
                     bits_d[i]  = '0;
                     shreg_d[i] = '0;
                  end else if (edge_det[i] && st_q[i] == ST_SYNC) begin
                     if (is_short[i]) st_d[i] = ST_HALF;
                     else             do_shift = 1'b1;
                  end else if (edge_det[i]) begin
                     st_d[i] = ST_SYNC;
                     if (is_short[i]) begin
                        do_shift = 1'b1;
                        bit_val  = 1'b1;
                     end else begin
                        bits_d[i]  = '0;
                        shreg_d[i] = '0;
                     end
                  end else if (tmo[i]) begin
                     st_d[i] = ST_IDLE;
                  end
               end
               default: st_d[i] = ST_IDLE;
            endcase
         end
         new_word[i] = {shreg_q[i][WORD_BITS-2:0], bit_val};
         if (do_shift) begin
            shreg_d[i] = new_word[i];
            if (bits_q[i] == BCW'(WORD_BITS - 1)) begin
               word_done[i] = 1'b1;
               bits_d[i]    = '0;
            end else begin
               bits_d[i] = bits_q[i] + BCW'(1);
            end
         end
      end
   end

   // The last cycle of a stop bit counts as free so packets can run back-to-back.
   always_comb begin
      frame_end = (u_st_q == U_SEND) && (baud_q == 16'(BAUD_EFF - 1)) &&
                  (bit_q == 4'd9) && (byte_q == 2'd2);
      uart_free = (u_st_q == U_IDLE) || frame_end;
      grant     = '0;
      sel_ch    = 2'd0;
      sel_w     = pend_w_q[0];
      if (uart_free) begin
         if (pend_v_q[0]) begin
            grant[0] = 1'b1;
            sel_ch   = 2'd0;
            sel_w    = pend_w_q[0];
         end else if (pend_v_q[1]) begin
            grant[1] = 1'b1;
            sel_ch   = 2'd1;
            sel_w    = pend_w_q[1];
         end else if (pend_v_q[2]) begin
            grant[2] = 1'b1;
            sel_ch   = 2'd2;
            sel_w    = pend_w_q[2];
         end
      end
      for (int i = 0; i < NCH; i++) begin
         pend_v_d[i] = pend_v_q[i] & ~grant[i];
         pend_w_d[i] = pend_w_q[i];
         if (word_done[i]) begin
            pend_v_d[i] = 1'b1;
            pend_w_d[i] = new_word[i];
         end
      end
   end

   // frame_q[0] is the bit currently on the line; an all-ones frame is idle.
   always_comb begin
      u_st_d  = u_st_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      frame_d = frame_q;
      rest_d  = rest_q;
      if (u_st_q == U_SEND) begin
         if (baud_q == 16'(BAUD_EFF - 1)) begin
            baud_d = '0;
            if (bit_q == 4'd9) begin
               bit_d = '0;
               if (byte_q == 2'd2) begin
                  u_st_d  = U_IDLE;
                  frame_d = '1;
               end else begin
                  byte_d  = byte_q + 2'd1;
                  frame_d = {1'b1, rest_q[15:8], 1'b0};
                  rest_d  = {rest_q[7:0], 8'h00};
               end
            end else begin
               bit_d   = bit_q + 4'd1;
               frame_d = {1'b1, frame_q[9:1]};
            end
         end else begin
            baud_d = baud_q + 16'd1;
         end
      end else begin
         frame_d = '1;
      end
      if (|grant) begin
         u_st_d  = U_SEND;
         baud_d  = '0;
         bit_d   = '0;
         byte_d  = '0;
         frame_d = {1'b1, sel_ch, 5'b00000, sel_w[WORD_BITS-1], 1'b0};
         rest_d  = sel_w[15:0];
      end
   end

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         data_meta_q <= '0;
         data_sync_q <= '0;
         data_prev_q <= '0;
         env_meta_q  <= '1;
         env_sync_q  <= '1;
         for (int i = 0; i < NCH; i++) begin
            st_q[i]     <= ST_IDLE;
            cnt_q[i]    <= '0;
            bits_q[i]   <= '0;
            shreg_q[i]  <= '0;
            pend_w_q[i] <= '0;
         end
         pend_v_q <= '0;
         u_st_q   <= U_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         byte_q   <= '0;
         frame_q  <= '1;
         rest_q   <= '0;
      end else begin
         data_meta_q <= data_meta_d;
         data_sync_q <= data_sync_d;
         data_prev_q <= data_prev_d;
         env_meta_q  <= env_meta_d;
         env_sync_q  <= env_sync_d;
         for (int i = 0; i < NCH; i++) begin
            st_q[i]     <= st_d[i];
            cnt_q[i]    <= cnt_d[i];
            bits_q[i]   <= bits_d[i];
            shreg_q[i]  <= shreg_d[i];
            pend_w_q[i] <= pend_w_d[i];
         end
         pend_v_q <= pend_v_d;
         u_st_q   <= u_st_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         frame_q  <= frame_d;
         rest_q   <= rest_d;
      end
   end

   assign tx = frame_q[0];

endmodule

// File: tb/tb_receivers_top_level_sim.sv
// Bench for receivers_top_level_sim: BMC stream drivers, a UART line monitor and a
// packet-level reference model feeding an expected byte queue.
`timescale 1ns/1ps
module tb_receivers_top_level_sim;
   localparam int BAUD    = 64;
   localparam int SHORT_T = 8;
   localparam int LONG_T  = 16;

   logic clk = 1'b0;
   logic rst;
   logic env0, env1, env2;
   logic d0, d1, d2;
   logic tx;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_edge_cyc = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   logic       rx_stop_q[$];
   int         rx_t_q[$];

   receivers_top_level_sim #(.BAUD_DIV(BAUD)) dut (
      .clk_25MHz     (clk),
      .reset         (rst),
      .envelop_wire_0(env0),
      .envelop_wire_1(env1),
      .envelop_wire_2(env2),
      .data_wire_0   (d0),
      .data_wire_1   (d1),
      .data_wire_2   (d2),
      .tx            (tx)
   );

   // ---------------- clock / reset ----------------
   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #(40 * 90000);
      $display("FAIL watchdog: simulation ran past its cycle budget");
      $fatal(1, "watchdog");
   end

   // ---------------- UART line monitor ----------------
   initial begin : rx_monitor
      logic [7:0] b;
      int         t0;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            t0 = cyc;
            repeat (BAUD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BAUD) @(negedge clk);
               b[i] = tx;
            end
            repeat (BAUD) @(negedge clk);
            rx_q.push_back(b);
            rx_stop_q.push_back(tx);
            rx_t_q.push_back(t0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic toggle(input int ch);
      case (ch)
         0:       d0 = ~d0;
         1:       d1 = ~d1;
         default: d2 = ~d2;
      endcase
   endtask

   function automatic int jittered(input int base, input int jit);
      int j;
      j = 0;
      if (jit > 0) j = int'($urandom_range(2 * jit, 0)) - jit;
      return base + j;
   endfunction

   // Biphase-mark: every bit ends with a transition; a 1 also toggles mid-bit.
   task automatic send_bits(input int ch, input logic [16:0] w, input int nbits,
                            input int jit, input bit with_sync);
      if (with_sync) toggle(ch);
      for (int i = nbits - 1; i >= 0; i--) begin
         if (w[i]) begin
            wait_cyc(jittered(SHORT_T, jit));
            toggle(ch);
            wait_cyc(jittered(SHORT_T, jit));
            toggle(ch);
         end else begin
            wait_cyc(jittered(LONG_T, jit));
            toggle(ch);
         end
      end
      last_edge_cyc = cyc;
   endtask

   task automatic wait_rx(input int n, input int budget, output bit ok);
      int k;
      k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      ok = (rx_q.size() >= n);
   endtask

   task automatic pop_rx(output logic [7:0] b, output logic st, output int t);
      if (rx_q.size() > 0) begin
         b  = rx_q.pop_front();
         st = rx_stop_q.pop_front();
         t  = rx_t_q.pop_front();
      end else begin
         b  = 8'hxx;
         st = 1'bx;
         t  = -1;
      end
   endtask

   function automatic logic [16:0] fold_bits(input bit b[17]);
      logic [16:0] w;
      w = '0;
      for (int i = 0; i < 17; i++) w = {w[15:0], b[i]};
      return w;
   endfunction

   // ---------------- reference model ----------------
   function automatic void model_packet(input int ch, input logic [16:0] w);
      exp_q.push_back({2'(ch), 5'b00000, w[16]});
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx_during: got %b want 1", tx); end
      wait_cyc(4);
      rst = 1'b0;
      wait_cyc(6);
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx_after: got %b want 1", tx); end
      total++;
      if (rx_q.size() != 0) begin bad++; $display("FAIL reset_no_bytes: got %0d want 0", rx_q.size()); end
   endtask

   task automatic test_ideal_and_continuation(input int jit, input string name);
      bit          b1[17] = '{1,1,0,1,1,1,0,1,1,1,0,0,1,0,0,1,1};
      bit          b2[17] = '{1,0,1,0,0,0,0,1,0,0,1,1,1,0,1,0,0};
      logic [7:0]  got, e;
      logic        st;
      int          t[6];
      int          edge1, lat, gap;
      bit          ok;
      exp_q.push_back(8'h01); exp_q.push_back(8'hBB); exp_q.push_back(8'h93);
      exp_q.push_back(8'h01); exp_q.push_back(8'h42); exp_q.push_back(8'h74);
      wait_cyc(40);
      send_bits(0, fold_bits(b1), 17, jit, 1'b1);
      edge1 = last_edge_cyc;
      send_bits(0, fold_bits(b2), 17, jit, 1'b0);
      wait_rx(6, 6000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL %s rx_count: got %0d want 6", name, rx_q.size()); end
      for (int k = 0; k < 6; k++) begin
         e = exp_q.pop_front();
         pop_rx(got, st, t[k]);
         total++;
         if (got !== e || st !== 1'b1) begin
            bad++;
            $display("FAIL %s byte%0d: got %02h stop=%b want %02h stop=1", name, k, got, st, e);
         end
      end
      lat = t[0] - edge1;
      total++;
      if (lat < 2 || lat > 6) begin bad++; $display("FAIL %s start_latency: got %0d want 2..6", name, lat); end
      for (int k = 0; k < 5; k++) begin
         gap = t[k+1] - t[k];
         total++;
         if (gap < 10 * BAUD || gap > 10 * BAUD + ((k == 2) ? 2 : 0)) begin
            bad++;
            $display("FAIL %s gap%0d: got %0d want %0d", name, k, gap, 10 * BAUD);
         end
      end
      wait_cyc(12 * BAUD);
      total++;
      if (rx_q.size() != 0) begin bad++; $display("FAIL %s extra_bytes: got %0d want 0", name, rx_q.size()); end
   endtask

   task automatic test_timeout();
      logic [16:0] w;
      logic [7:0]  got, e;
      logic        st;
      int          t;
      bit          ok;
      w = 17'($urandom) | 17'h10000;
      wait_cyc(40);
      send_bits(2, 17'($urandom), 10, 0, 1'b1);
      wait_cyc(200);
      send_bits(2, w, 17, 0, 1'b1);
      model_packet(2, w);
      wait_rx(3, 3000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL timeout rx_count: got %0d want 3", rx_q.size()); end
      for (int k = 0; k < 3; k++) begin
         e = exp_q.pop_front();
         pop_rx(got, st, t);
         total++;
         if (got !== e || st !== 1'b1) begin
            bad++;
            $display("FAIL timeout byte%0d: got %02h stop=%b want %02h stop=1", k, got, st, e);
         end
      end
      wait_cyc(12 * BAUD);
      total++;
      if (rx_q.size() != 0) begin bad++; $display("FAIL timeout extra_bytes: got %0d want 0", rx_q.size()); end
   endtask

   task automatic test_envelope();
      int lows;
      lows = 0;
      env1 = 1'b1;
      wait_cyc(10);
      fork
         send_bits(1, 17'($urandom), 17, 0, 1'b1);
         begin
            repeat (2400) begin
               @(negedge clk);
               if (tx !== 1'b1) lows++;
            end
         end
      join
      total++;
      if (lows != 0) begin bad++; $display("FAIL envelope tx_low_cycles: got %0d want 0", lows); end
      total++;
      if (rx_q.size() != 0) begin bad++; $display("FAIL envelope bytes: got %0d want 0", rx_q.size()); end
      env1 = 1'b0;
      wait_cyc(10);
   endtask

   task automatic test_simultaneous();
      logic [16:0] wa, wb, wc;
      logic [7:0]  got, e;
      logic        st;
      int          t;
      bit          ok;
      wa = 17'($urandom);
      wb = 17'($urandom);
      wc = 17'($urandom);
      wait_cyc(40);
      fork
         send_bits(0, wa, 17, 0, 1'b1);
         send_bits(1, wb, 17, 0, 1'b1);
         send_bits(2, wc, 17, 0, 1'b1);
      join
      model_packet(0, wa);
      model_packet(1, wb);
      model_packet(2, wc);
      wait_rx(9, 7000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL simultaneous rx_count: got %0d want 9", rx_q.size()); end
      for (int k = 0; k < 9; k++) begin
         e = exp_q.pop_front();
         pop_rx(got, st, t);
         total++;
         if (got !== e || st !== 1'b1) begin
            bad++;
            $display("FAIL simultaneous byte%0d: got %02h stop=%b want %02h stop=1", k, got, st, e);
         end
      end
   endtask

   task automatic test_random(input int n);
      logic [16:0] w;
      logic [7:0]  got, e;
      logic        st;
      int          t, ch, jit;
      bit          ok;
      for (int r = 0; r < n; r++) begin
         ch  = int'($urandom_range(2, 0));
         jit = int'($urandom_range(3, 0));
         w   = 17'($urandom);
         wait_cyc(40);
         send_bits(ch, w, 17, jit, 1'b1);
         model_packet(ch, w);
         wait_rx(3, 3000, ok);
         total++;
         if (!ok) begin bad++; $display("FAIL random%0d rx_count: got %0d want 3", r, rx_q.size()); end
         for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            pop_rx(got, st, t);
            total++;
            if (got !== e || st !== 1'b1) begin
               bad++;
               $display("FAIL random%0d ch%0d byte%0d: got %02h stop=%b want %02h stop=1",
                        r, ch, k, got, st, e);
            end
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [16:0] w;
      logic [7:0]  got, e;
      logic        st;
      int          t, lows;
      bit          ok;
      // byte1 all zeros keeps the line low throughout its data bits
      w = {1'b1, 8'h00, 8'($urandom)};
      wait_cyc(40);
      send_bits(1, w, 17, 0, 1'b1);
      wait_rx(1, 3000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL midreset first_byte: got %0d want 1", rx_q.size()); end
      wait_cyc(3 * BAUD);
      total++;
      if (tx !== 1'b0) begin bad++; $display("FAIL midreset tx_before: got %b want 0", tx); end
      #3 rst = 1'b1;
      #1;
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL midreset tx_on_reset: got %b want 1", tx); end
      wait_cyc(3);
      rst = 1'b0;
      lows = 0;
      repeat (25 * BAUD) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      total++;
      if (lows != 0) begin bad++; $display("FAIL midreset tx_low_after: got %0d want 0", lows); end
      rx_q.delete();
      rx_stop_q.delete();
      rx_t_q.delete();
      w = 17'($urandom);
      send_bits(1, w, 17, 0, 1'b1);
      model_packet(1, w);
      wait_rx(3, 3000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL midreset rx_count: got %0d want 3", rx_q.size()); end
      for (int k = 0; k < 3; k++) begin
         e = exp_q.pop_front();
         pop_rx(got, st, t);
         total++;
         if (got !== e || st !== 1'b1) begin
            bad++;
            $display("FAIL midreset byte%0d: got %02h stop=%b want %02h stop=1", k, got, st, e);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst  = 1'b1;
      env0 = 1'b0;
      env1 = 1'b0;
      env2 = 1'b0;
      d0   = 1'b0;
      d1   = 1'b0;
      d2   = 1'b0;
      #1;
      test_reset();
      test_ideal_and_continuation(0, "ideal");
      test_ideal_and_continuation(3, "jitter");
      test_timeout();
      test_envelope();
      test_simultaneous();
      test_random(4);
      test_reset_mid_packet();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
